// File: rtl/cpu_run_pkg.sv
// Shared types for the CPU run controller: FSM state encoding and stop-reason codes.
// The optional breakpoint stop is enabled by the macro CPU_RUN_CTRL_BREAK_EN.
package cpu_run_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [1:0] REASON_NONE    = 2'd0;
   localparam logic [1:0] REASON_HALT    = 2'd1;
   localparam logic [1:0] REASON_TIMEOUT = 2'd2;
   localparam logic [1:0] REASON_BREAK   = 2'd3;

endpackage : cpu_run_pkg

// File: rtl/cpu_run_ctrl.sv
// Run controller for the basic CPU: on start it holds the CPU in reset for RST_CYC
// cycles, runs it while counting cycles, stops on halt / breakpoint / timeout and
// snapshots the probed registers. Optional macro CPU_RUN_CTRL_BREAK_EN adds a
// PC breakpoint (brk_arm, brk_pc, brk_hit).
module cpu_run_ctrl
   import cpu_run_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int NPROBE  = 3,
   parameter int PC_W    = 8,
   parameter int RST_CYC = 2,
   parameter int MAX_CYC = 16,
   parameter int CNT_W   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
`ifdef CPU_RUN_CTRL_BREAK_EN
   input  logic                     brk_arm,
   input  logic [PC_W-1:0]          brk_pc,
   output logic                     brk_hit,
`endif
   input  logic                     start,
   input  logic                     halt_i,
   input  logic [PC_W-1:0]          pc_i,
   input  logic [NPROBE*DATA_W-1:0] probe_i,
   output logic                     cpu_rst,
   output logic                     running,
   output logic [CNT_W-1:0]         cycle_cnt,
   output logic                     done,
   output logic [1:0]               stop_reason,
   output logic                     snap_valid,
   output logic [NPROBE*DATA_W-1:0] snap_data
);

   // RST_CYC-1 must fit; a 1-bit counter covers RST_CYC of 1 or 2
   localparam int HOLD_W = (RST_CYC > 2) ? $clog2(RST_CYC) : 1;

   state_t                    r_state;
   state_t                    w_next;
   logic [HOLD_W-1:0]         r_hold_cnt;
   logic [CNT_W-1:0]          r_cycle_cnt;
   logic [CNT_W-1:0]          w_cnt_inc;
   logic [1:0]                r_reason;
   logic [1:0]                w_reason;
   logic                      w_stop;
   logic                      w_timeout;
   logic                      w_brk;
   logic                      w_start_ok;
   logic                      r_cpu_rst;
   logic                      r_running;
   logic                      r_done;
   logic                      r_snap_valid;
   logic [NPROBE*DATA_W-1:0]  r_snap_data;

`ifdef CPU_RUN_CTRL_BREAK_EN
   logic                      r_brk_hit;
   assign w_brk   = brk_arm && (pc_i == brk_pc);
   assign brk_hit = r_brk_hit;
`else
   // pc_i only feeds the breakpoint comparator, which is absent in this build
   logic                      w_unused_pc;
   assign w_brk       = 1'b0;
   assign w_unused_pc = ^pc_i;
`endif

   // Next-state logic, stop detection and reason priority (halt > break > timeout)
   always_comb begin
      w_next     = r_state;
      w_stop     = 1'b0;
      w_reason   = REASON_NONE;
      w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
      if (r_cycle_cnt == {CNT_W{1'b1}}) begin
         w_cnt_inc = r_cycle_cnt;
      end else begin
         w_cnt_inc = r_cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      w_timeout  = (MAX_CYC != 0) && (w_cnt_inc == CNT_W'(MAX_CYC));
      case (r_state)
         ST_IDLE: begin
            if (start) w_next = ST_HOLD;
            else       w_next = ST_IDLE;
         end
         ST_HOLD: begin
            if (r_hold_cnt == {HOLD_W{1'b0}}) w_next = ST_RUN;
            else                               w_next = ST_HOLD;
         end
         ST_RUN: begin
            if (halt_i) begin
               w_stop   = 1'b1;
               w_reason = REASON_HALT;
            end else if (w_brk) begin
               w_stop   = 1'b1;
               w_reason = REASON_BREAK;
            end else if (w_timeout) begin
               w_stop   = 1'b1;
               w_reason = REASON_TIMEOUT;
            end else begin
               w_stop   = 1'b0;
               w_reason = REASON_NONE;
            end
            if (w_stop) w_next = ST_DONE;
            else        w_next = ST_RUN;
         end
         ST_DONE: begin
            if (start) w_next = ST_HOLD;
            else       w_next = ST_DONE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // State register plus the state-decoded control outputs, registered from next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_cpu_rst <= 1'b1;
         r_running <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_cpu_rst <= (w_next != ST_RUN);
         r_running <= (w_next == ST_RUN);
         r_done    <= (w_next == ST_DONE);
      end
   end

   // Reset-hold down-counter: loaded on HOLD entry, RUN follows when it reads zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hold_cnt <= {HOLD_W{1'b0}};
      end else if (w_start_ok) begin
         r_hold_cnt <= HOLD_W'(RST_CYC - 1);
      end else if ((r_state == ST_HOLD) && (r_hold_cnt != {HOLD_W{1'b0}})) begin
         r_hold_cnt <= r_hold_cnt - {{(HOLD_W-1){1'b0}}, 1'b1};
      end
   end

   // Cycle counter, stop reason and probe snapshot; cleared on an accepted start
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cycle_cnt  <= {CNT_W{1'b0}};
         r_reason     <= REASON_NONE;
         r_snap_valid <= 1'b0;
         r_snap_data  <= {(NPROBE*DATA_W){1'b0}};
      end else if (w_start_ok) begin
         r_cycle_cnt  <= {CNT_W{1'b0}};
         r_reason     <= REASON_NONE;
         r_snap_valid <= 1'b0;
      end else if (r_state == ST_RUN) begin
         r_cycle_cnt <= w_cnt_inc;
         if (w_stop) begin
            r_reason     <= w_reason;
            r_snap_valid <= 1'b1;
            r_snap_data  <= probe_i;
         end
      end
   end

`ifdef CPU_RUN_CTRL_BREAK_EN
   // Breakpoint-hit flag: set on a breakpoint stop, cleared by an accepted start
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_brk_hit <= 1'b0;
      end else if (w_start_ok) begin
         r_brk_hit <= 1'b0;
      end else if ((r_state == ST_RUN) && w_stop && (w_reason == REASON_BREAK)) begin
         r_brk_hit <= 1'b1;
      end
   end
`endif

   assign cpu_rst     = r_cpu_rst;
   assign running     = r_running;
   assign done        = r_done;
   assign cycle_cnt   = r_cycle_cnt;
   assign stop_reason = r_reason;
   assign snap_valid  = r_snap_valid;
   assign snap_data   = r_snap_data;

endmodule : cpu_run_ctrl

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: stimulus pushes the expected stop record,
// a monitor pops and compares it whenever done rises.
module tb_cpu_run_ctrl;

   typedef struct packed {
      logic [1:0]  reason;
      logic [15:0] cnt;
      logic [23:0] snap;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        halt_i = 1'b0;
   logic [7:0]  pc_i = 8'd0;
   logic [23:0] probe_i = 24'd0;
   logic        cpu_rst, running, done, snap_valid;
   logic [15:0] cycle_cnt;
   logic [1:0]  stop_reason;
   logic [23:0] snap_data;

   logic        start0 = 1'b0;
   logic        halt0 = 1'b0;
   logic        cpu_rst0, running0, done0, snap_valid0;
   logic [15:0] cycle_cnt0;
   logic [1:0]  stop_reason0;
   logic [23:0] snap_data0;

`ifdef CPU_RUN_CTRL_BREAK_EN
   logic        brk_arm = 1'b0;
   logic [7:0]  brk_pc = 8'd0;
   logic        brk_hit;
   logic        brk_hit0;
`endif

   int   total = 0;
   int   bad = 0;
   exp_t q[$];
   logic prev_done = 1'b0;

   always #5 clk = ~clk;

   cpu_run_ctrl #(.DATA_W(8), .NPROBE(3), .PC_W(8), .RST_CYC(2), .MAX_CYC(16), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset),
`ifdef CPU_RUN_CTRL_BREAK_EN
      .brk_arm(brk_arm), .brk_pc(brk_pc), .brk_hit(brk_hit),
`endif
      .start(start), .halt_i(halt_i), .pc_i(pc_i), .probe_i(probe_i),
      .cpu_rst(cpu_rst), .running(running), .cycle_cnt(cycle_cnt), .done(done),
      .stop_reason(stop_reason), .snap_valid(snap_valid), .snap_data(snap_data)
   );

   cpu_run_ctrl #(.DATA_W(8), .NPROBE(3), .PC_W(8), .RST_CYC(2), .MAX_CYC(0), .CNT_W(16)) u_dut0 (
      .clk(clk), .reset(reset),
`ifdef CPU_RUN_CTRL_BREAK_EN
      .brk_arm(1'b0), .brk_pc(8'd0), .brk_hit(brk_hit0),
`endif
      .start(start0), .halt_i(halt0), .pc_i(pc_i), .probe_i(probe_i),
      .cpu_rst(cpu_rst0), .running(running0), .cycle_cnt(cycle_cnt0), .done(done0),
      .stop_reason(stop_reason0), .snap_valid(snap_valid0), .snap_data(snap_data0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: on each rising done, pop the oldest expected stop record and compare
   always @(negedge clk) begin
      if (done && !prev_done) begin
         if (q.size() == 0) begin
            chk("unexpected_stop", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("stop_reason", {30'd0, stop_reason}, {30'd0, e.reason});
            chk("cycle_cnt", {16'd0, cycle_cnt}, {16'd0, e.cnt});
            chk("snap_data", {8'd0, snap_data}, {8'd0, e.snap});
            chk("snap_valid", {31'd0, snap_valid}, 32'd1);
            chk("running_in_done", {31'd0, running}, 32'd0);
            chk("cpu_rst_in_done", {31'd0, cpu_rst}, 32'd1);
         end
      end
      prev_done = done;
   end

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("done_within_budget", {31'd0, done}, 32'd1);
      @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
      chk({tag, "_running"}, {31'd0, running}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_snap_valid"}, {31'd0, snap_valid}, 32'd0);
      chk({tag, "_cycle_cnt"}, {16'd0, cycle_cnt}, 32'd0);
      chk({tag, "_stop_reason"}, {30'd0, stop_reason}, 32'd0);
      chk({tag, "_snap_data"}, {8'd0, snap_data}, 32'd0);
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk_reset_vals("rst");
      reset = 1'b0;
      @(negedge clk);
      chk("idle_cpu_rst", {31'd0, cpu_rst}, 32'd1);

      // halt in RUN cycle 9, probes {7,5,2}
      q.push_back('{reason: 2'd1, cnt: 16'd9, snap: 24'h070502});
      pulse_start();
      @(negedge clk); chk("hold1_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      @(negedge clk); chk("hold2_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      @(negedge clk); chk("run1_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      chk("run1_running", {31'd0, running}, 32'd1);
      repeat (8) @(negedge clk);
      halt_i = 1'b1; probe_i = {8'd7, 8'd5, 8'd2};
      @(negedge clk);
      halt_i = 1'b0; probe_i = 24'hFFFFFF;
      wait_done(10);

      // timeout run from DONE; start pulses in HOLD and RUN must be ignored
      probe_i = 24'hA1B2C3;
      q.push_back('{reason: 2'd2, cnt: 16'd16, snap: 24'hA1B2C3});
      pulse_start();
      chk("restart_done_drop", {31'd0, done}, 32'd0);
      chk("restart_snap_valid", {31'd0, snap_valid}, 32'd0);
      chk("restart_cnt_clear", {16'd0, cycle_cnt}, 32'd0);
      pulse_start();
      chk("start_in_hold_ignored", {31'd0, cpu_rst}, 32'd0);
      repeat (3) @(negedge clk);
      pulse_start();
      chk("start_in_run_ignored", {31'd0, cpu_rst}, 32'd0);
      chk("start_in_run_running", {31'd0, running}, 32'd1);
      wait_done(40);

      // halt coinciding with timeout in RUN cycle 16
      probe_i = 24'h112233;
      q.push_back('{reason: 2'd1, cnt: 16'd16, snap: 24'h112233});
      pulse_start();
      repeat (3) @(negedge clk);
      repeat (15) @(negedge clk);
      halt_i = 1'b1;
      @(negedge clk);
      halt_i = 1'b0;
      wait_done(10);

      // asynchronous reset while DONE, checked between clock edges
      chk("pre_reset_done", {31'd0, done}, 32'd1);
      reset = 1'b1;
      #1 chk_reset_vals("async_rst");
      #1 reset = 1'b0;
      @(negedge clk);

`ifdef CPU_RUN_CTRL_BREAK_EN
      // breakpoint at pc 5 with pc counting up from 0 in RUN
      brk_arm = 1'b1; brk_pc = 8'h05; pc_i = 8'd0; probe_i = 24'h0A0B0C;
      q.push_back('{reason: 2'd3, cnt: 16'd6, snap: 24'h0A0B0C});
      pulse_start();
      chk("brk_hit_clear", {31'd0, brk_hit}, 32'd0);
      repeat (3) @(negedge clk);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         pc_i = 8'(i);
      end
      wait_done(10);
      chk("brk_hit_set", {31'd0, brk_hit}, 32'd1);
      brk_arm = 1'b0; pc_i = 8'd0;
`endif

      // MAX_CYC=0 instance keeps running without a timeout
      @(posedge clk); #1 start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      repeat (1000) @(posedge clk);
      #1;
      chk("notimeout_running", {31'd0, running0}, 32'd1);
      chk("notimeout_done", {31'd0, done0}, 32'd0);
      chk("notimeout_cnt", {16'd0, cycle_cnt0}, 32'd998);

      @(negedge clk);
      chk("scoreboard_empty", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_cpu_run_ctrl
